// File: rtl/freq_word_ctrl_pkg.sv
// freq_word_ctrl_pkg: shared widths, step table, action encoding and harmonic multipliers
package freq_ctrl_pkg;
    localparam int WORD_W = 24;
    localparam int STEP_IDX_MAX = 5;
    localparam logic [WORD_W-1:0] STEP_TABLE [STEP_IDX_MAX+1] = '{
        24'd1, 24'd10, 24'd100, 24'd1000, 24'd10000, 24'd100000
    };
    typedef enum logic [1:0] {ACT_NONE, ACT_INC, ACT_DEC, ACT_PRESET} act_t;
    function automatic logic [WORD_W-1:0] mul3(input logic [WORD_W-1:0] b);
        return (b << 1) + b;
    endfunction
    function automatic logic [WORD_W-1:0] mul5(input logic [WORD_W-1:0] b);
        return (b << 2) + b;
    endfunction
endpackage

// File: rtl/freq_word_ctrl_if.sv
// freq_word_ctrl_if: key levels in, frequency words and status out
interface freq_word_ctrl_if;
    import freq_ctrl_pkg::*;
    logic k0, k1, k2, k3, k4, k5;
    logic [WORD_W-1:0] freq_1, freq_3, freq_5;
    logic [2:0] step_idx;
    logic harm_en;
    logic upd;
    modport master (
        output k0, k1, k2, k3, k4, k5,
        input freq_1, freq_3, freq_5, step_idx, harm_en, upd
    );
    modport slave (
        input k0, k1, k2, k3, k4, k5,
        output freq_1, freq_3, freq_5, step_idx, harm_en, upd
    );
endinterface

// File: rtl/freq_word_ctrl_key_repeat.sv
// key_repeat: fires on a key's rising edge, then after RPT_DLY cycles and every RPT_PER cycles while held
module key_repeat #(
    parameter int RPT_DLY = 25000000,
    parameter int RPT_PER = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    input  logic prev,
    input  logic clr,
    output logic fire
);
    localparam int CW = $clog2(RPT_DLY + 1);
    logic [CW-1:0] cnt;
    logic hit;
    assign hit = cnt == CW'(RPT_DLY);
    assign fire = lvl & ~clr & (~prev | hit);
    // hold counter: starts at the edge, reloads so the next hit is RPT_PER cycles later
    always_ff @(posedge clk) begin
        if (rst || clr || !lvl)
            cnt <= '0;
        else if (!prev)
            cnt <= CW'(1);
        else if (hit)
            cnt <= CW'(RPT_DLY - RPT_PER + 1);
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/freq_word_ctrl.sv
// freq_word_ctrl: keys to saturating base frequency word plus 3rd/5th harmonic words
module freq_word_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int F_DEFAULT = 1678,
    parameter int F_MIN     = 1,
    parameter int F_MAX     = 3355443,
    parameter int RPT_DLY   = 25000000,
    parameter int RPT_PER   = 5000000,
    parameter int STEP_DEF  = 2
) (
    input logic clk,
    input logic rst,
    freq_word_ctrl_if.slave bus
);
    logic [5:0] k, prev;
    logic [5:2] rise;
    logic both, fire_inc, fire_dec;
    act_t act;
    logic [WORD_W-1:0] base, base_nxt, step, inc_val, dec_val, f1, f3, f5, f3_n, f5_n;
    logic [WORD_W:0] sum, diff;
    logic [2:0] step_idx, idx_up, idx_nxt;
    logic harm_en, upd;

    assign k = {bus.k5, bus.k4, bus.k3, bus.k2, bus.k1, bus.k0};
    assign rise = k[5:2] & ~prev[5:2];
    assign both = k[0] & k[1];

    key_repeat #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) u_inc (
        .clk(clk), .rst(rst), .lvl(k[0]), .prev(prev[0]), .clr(both), .fire(fire_inc)
    );
    key_repeat #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) u_dec (
        .clk(clk), .rst(rst), .lvl(k[1]), .prev(prev[1]), .clr(both), .fire(fire_dec)
    );

    // next base word and step index; preset beats inc/dec, step moves use the old step
    always_comb begin
        act = rise[4] ? ACT_PRESET : fire_inc ? ACT_INC : fire_dec ? ACT_DEC : ACT_NONE;
        step = STEP_TABLE[step_idx];
        sum = {1'b0, base} + {1'b0, step};
        diff = {1'b0, base} - {1'b0, step};
        inc_val = (sum > (WORD_W+1)'(F_MAX)) ? WORD_W'(F_MAX) : sum[WORD_W-1:0];
        dec_val = (diff[WORD_W] || diff < (WORD_W+1)'(F_MIN)) ? WORD_W'(F_MIN) : diff[WORD_W-1:0];
        base_nxt = act == ACT_PRESET ? WORD_W'(F_DEFAULT) :
                   act == ACT_INC    ? inc_val :
                   act == ACT_DEC    ? dec_val : base;
        idx_up = (rise[2] && step_idx < 3'(STEP_IDX_MAX)) ? step_idx + 3'd1 : step_idx;
        idx_nxt = (rise[3] && idx_up != 3'd0) ? idx_up - 3'd1 : idx_up;
        f3_n = harm_en ? mul3(base) : '0;
        f5_n = harm_en ? mul5(base) : '0;
    end

    // stage 1: edge registers, base word, step index and harmonic enable
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            base <= WORD_W'(F_DEFAULT);
            step_idx <= 3'(STEP_DEF);
            harm_en <= 1'b1;
        end else begin
            prev <= k;
            base <= base_nxt;
            step_idx <= idx_nxt;
            harm_en <= harm_en ^ rise[5];
        end
    end

    // stage 2: registered output words, strobe only when a word actually changes
    always_ff @(posedge clk) begin
        if (rst) begin
            f1 <= WORD_W'(F_DEFAULT);
            f3 <= mul3(WORD_W'(F_DEFAULT));
            f5 <= mul5(WORD_W'(F_DEFAULT));
            upd <= 1'b0;
        end else begin
            f1 <= base;
            f3 <= f3_n;
            f5 <= f5_n;
            upd <= {base, f3_n, f5_n} != {f1, f3, f5};
        end
    end

    assign bus.freq_1 = f1;
    assign bus.freq_3 = f3;
    assign bus.freq_5 = f5;
    assign bus.step_idx = step_idx;
    assign bus.harm_en = harm_en;
    assign bus.upd = upd;
endmodule
